// File: rtl/hy_riscv_regfile_port_sequencer_pkg.sv
// hy_riscv_pkg
//   Shared definitions for the register-file port sequencer slice:
//   default data/index widths and the sequencer state type.
//   No ports; imported by hy_riscv_wb_buffer and hy_riscv_regfile_port_sequencer.
package hy_riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_ID_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    OUT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/hy_riscv_regfile_port_sequencer_wb_buffer.sv
// hy_riscv_wb_buffer
//   Single-entry holding register for a pending writeback.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset (empties the entry)
//     push_valid_i     writeback offered
//     push_ready_o     entry empty; an offered writeback is taken this cycle
//     push_rd_i        destination index of the offered writeback
//     push_data_i      destination value of the offered writeback
//     clear_i          drop the held entry at this edge (it has been issued)
//     valid_o          entry holds a writeback
//     rd_o, data_o     held destination index / value
module hy_riscv_wb_buffer
  import hy_riscv_pkg::*;
#(
  parameter int unsigned DATA_W = hy_riscv_pkg::XLEN,
  parameter int unsigned ID_W   = hy_riscv_pkg::REG_ID_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [ID_W-1:0]   push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              clear_i,
  output logic              valid_o,
  output logic [ID_W-1:0]   rd_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ID_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign push_ready_o = !valid_q;

  // Push is only possible while empty and clear only while full, so the two
  // never collide on the same edge.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (push_valid_i && !valid_q) begin
      valid_d = 1'b1;
      rd_d    = push_rd_i;
      data_d  = push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hy_riscv_regfile_port_sequencer.sv
// hy_riscv_regfile_port_sequencer
//   Serialises the rs1 read, rs2 read and one buffered writeback of each
//   transaction onto the single register_id port of hy_riscv_register_set,
//   and hands both operands to execute over a valid/ready handshake.
//   x0 always reads as 0 and is never written.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     req_valid/req_ready           operand request from decode
//     req_rs1, req_rs2              source register indices
//     wb_valid/wb_ready             writeback from retire (1-entry buffer)
//     wb_rd, wb_data                writeback destination / value
//     op_valid/op_ready             operands to execute
//     op_rs1_val, op_rs2_val        operand values
//     rf_set_reg, rf_get_reg        register-set write / read strobes
//     rf_register_id, rf_value      register-set index / write data
//     rf_value_out                  register-set read data (combinational)
//   Build option: define HY_RF_WB_BYPASS_EN to forward a buffered writeback
//   into the RD1/RD2 operand capture when its index matches.
module hy_riscv_regfile_port_sequencer
  import hy_riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REG_ID_W-1:0] req_rs1,
  input  logic [REG_ID_W-1:0] req_rs2,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [REG_ID_W-1:0] wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [XLEN-1:0]     op_rs1_val,
  output logic [XLEN-1:0]     op_rs2_val,
  output logic                rf_set_reg,
  output logic                rf_get_reg,
  output logic [REG_ID_W-1:0] rf_register_id,
  output logic [XLEN-1:0]     rf_value,
  input  logic [XLEN-1:0]     rf_value_out
);

  seq_state_t          state_q, state_d;
  logic [REG_ID_W-1:0] rs1_q, rs1_d;
  logic [REG_ID_W-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0]     op1_q, op1_d;
  logic [XLEN-1:0]     op2_q, op2_d;

  logic                wb_buf_valid;
  logic [REG_ID_W-1:0] wb_buf_rd;
  logic [XLEN-1:0]     wb_buf_data;
  logic                wb_push_ready;
  logic                wb_clear;

  logic                req_fire;
  logic [XLEN-1:0]     rd1_val;
  logic [XLEN-1:0]     rd2_val;

  // A buffered writeback is retired in IDLE; it owns the port that cycle,
  // so requests are only taken in IDLE with the buffer empty.
  assign wb_clear = (state_q == IDLE) && wb_buf_valid;
  assign req_fire = (state_q == IDLE) && !wb_buf_valid && req_valid;

  hy_riscv_wb_buffer #(
    .DATA_W (XLEN),
    .ID_W   (REG_ID_W)
  ) u_wb_buffer (
    .clk_i        (clk),
    .reset_i      (reset),
    .push_valid_i (wb_valid),
    .push_ready_o (wb_push_ready),
    .push_rd_i    (wb_rd),
    .push_data_i  (wb_data),
    .clear_i      (wb_clear),
    .valid_o      (wb_buf_valid),
    .rd_o         (wb_buf_rd),
    .data_o       (wb_buf_data)
  );

  // Operand source selection; x0 reads as 0 regardless of the register set.
`ifdef HY_RF_WB_BYPASS_EN
  always_comb begin
    rd1_val = rf_value_out;
    if (wb_buf_valid && (wb_buf_rd == rs1_q)) begin
      rd1_val = wb_buf_data;
    end
    if (rs1_q == '0) begin
      rd1_val = '0;
    end
  end

  always_comb begin
    rd2_val = rf_value_out;
    if (wb_buf_valid && (wb_buf_rd == rs2_q)) begin
      rd2_val = wb_buf_data;
    end
    if (rs2_q == '0) begin
      rd2_val = '0;
    end
  end
`else
  assign rd1_val = (rs1_q == '0) ? '0 : rf_value_out;
  assign rd2_val = (rs2_q == '0) ? '0 : rf_value_out;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = OUT;
      OUT:     if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is high.
  always_comb begin
    req_ready      = 1'b0;
    op_valid       = 1'b0;
    rf_set_reg     = 1'b0;
    rf_get_reg     = 1'b0;
    rf_register_id = '0;
    rf_value       = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (wb_buf_valid) begin
            // A write to x0 is dropped: no strobe, buffer still clears.
            if (wb_buf_rd != '0) begin
              rf_set_reg     = 1'b1;
              rf_register_id = wb_buf_rd;
              rf_value       = wb_buf_data;
            end
          end else begin
            req_ready = 1'b1;
          end
        end
        RD1: begin
          rf_get_reg     = 1'b1;
          rf_register_id = rs1_q;
        end
        RD2: begin
          rf_get_reg     = 1'b1;
          rf_register_id = rs2_q;
        end
        OUT: begin
          op_valid = 1'b1;
        end
        default: begin
          op_valid = 1'b0;
        end
      endcase
    end
  end

  assign wb_ready   = !reset && wb_push_ready;
  assign op_rs1_val = reset ? '0 : op1_q;
  assign op_rs2_val = reset ? '0 : op2_q;

  // Request index latch and operand capture
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    op1_d = op1_q;
    op2_d = op2_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          rs1_d = req_rs1;
          rs2_d = req_rs2;
        end
      end
      RD1:     op1_d = rd1_val;
      RD2:     op2_d = rd2_val;
      default: op1_d = op1_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q <= '0;
      rs2_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

endmodule

// File: tb/tb_hy_riscv_regfile_port_sequencer.sv
// Testbench for hy_riscv_regfile_port_sequencer.
// Models the external register set as an array served combinationally on
// rf_register_id, and keeps an architectural view (gold) of every register
// updated from the writebacks the bench issues.
module tb_hy_riscv_regfile_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] op_rs1_val;
  logic [31:0] op_rs2_val;
  logic        rf_set_reg;
  logic        rf_get_reg;
  logic [4:0]  rf_register_id;
  logic [31:0] rf_value;
  logic [31:0] rf_value_out;

  int checks = 0;
  int failures = 0;

  hy_riscv_regfile_port_sequencer #(
    .XLEN     (32),
    .REG_ID_W (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_rs1_val     (op_rs1_val),
    .op_rs2_val     (op_rs2_val),
    .rf_set_reg     (rf_set_reg),
    .rf_get_reg     (rf_get_reg),
    .rf_register_id (rf_register_id),
    .rf_value       (rf_value),
    .rf_value_out   (rf_value_out)
  );

  always #5 clk = ~clk;

  // External register set. x0 holds junk so the x0 guard is visible.
  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hBAD0_BAD0;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  logic        mem_load = 1'b1;
  logic [31:0] rf_mem [32];
  logic [31:0] gold   [32];

  assign rf_value_out = rf_mem[rf_register_id];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
    end else if (rf_set_reg) begin
      rf_mem[rf_register_id] <= rf_value;
    end
  end

  // Port-protocol violation counters, inspected by test_invariants.
  int mon_excl = 0;
  int mon_idle_nz = 0;
  int mon_x0 = 0;

  always @(negedge clk) begin
    if (rf_set_reg === 1'b1 && rf_get_reg === 1'b1) mon_excl++;
    if (rf_set_reg !== 1'b1 && rf_get_reg !== 1'b1 &&
        (rf_register_id !== 5'd0 || rf_value !== 32'd0)) mon_idle_nz++;
    if (rf_set_reg === 1'b1 && rf_register_id === 5'd0) mon_x0++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a request (optionally with a concurrent writeback), wait for
  // acceptance and then for op_valid. lat = edges from accept edge to op_valid.
  task automatic start_req(input logic [4:0] rs1, input logic [4:0] rs2,
                           input bit wb_en, input logic [4:0] rd,
                           input logic [31:0] data, output int lat, output bit to);
    int n;
    bit wb_pend, acc_wb, acc_req;
    to = 1'b0; lat = 0; n = 0; wb_pend = wb_en;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2;
    if (wb_en) begin wb_valid = 1'b1; wb_rd = rd; wb_data = data; end
    settle();
    forever begin
      acc_wb  = wb_pend && (wb_ready === 1'b1);
      acc_req = (req_ready === 1'b1);
      tick();
      if (acc_wb) begin wb_pend = 1'b0; wb_valid = 1'b0; end
      if (acc_req) break;
      n++;
      if (n > 20) begin to = 1'b1; req_valid = 1'b0; wb_valid = 1'b0; return; end
      settle();
    end
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    lat = 1;
    settle();
    while (op_valid !== 1'b1) begin
      if (lat >= 20) begin to = 1'b1; return; end
      tick(); settle(); lat++;
    end
  endtask

  task automatic finish_op();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    settle();
  endtask

  // Issue a lone writeback from IDLE and let it reach the register set.
  task automatic do_wb(input logic [4:0] rd, input logic [31:0] data, output bit to);
    int n;
    to = 1'b0; n = 0;
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    settle();
    while (wb_ready !== 1'b1) begin
      if (n > 20) begin to = 1'b1; wb_valid = 1'b0; return; end
      tick(); settle(); n++;
    end
    tick();
    wb_valid = 1'b0;
    tick();
    settle();
  endtask

  task automatic test_reset();
    logic [6:0] strobes;
    reset = 1'b1; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678; op_ready = 1'b1;
    repeat (3) tick();
    mem_load = 1'b0;
    settle();
    strobes = {req_ready, wb_ready, op_valid, rf_set_reg, rf_get_reg,
               |rf_register_id, |rf_value};
    checks++;
    if (strobes !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl_outputs: got %b want 0000000", strobes);
    end
    checks++;
    if (op_rs1_val !== 32'd0 || op_rs2_val !== 32'd0) begin
      failures++; $display("FAIL reset_operands: got %h/%h want 0/0", op_rs1_val, op_rs2_val);
    end
    reset = 1'b0; req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0;
    settle();
    checks++;
    if ({req_ready, wb_ready, op_valid} !== 3'b110) begin
      failures++; $display("FAIL post_reset_idle: got %b want 110", {req_ready, wb_ready, op_valid});
    end
    tick(); settle();
  endtask

  task automatic test_plain_read();
    bit to; int lat;
    do_wb(5'd5, 32'hDEAD_BEEF, to); gold[5] = 32'hDEAD_BEEF;
    checks++;
    if (to) begin failures++; $display("FAIL plain_wb5_timeout: got timeout want accept"); end
    do_wb(5'd6, 32'h1234_5678, to); gold[6] = 32'h1234_5678;
    checks++;
    if (to) begin failures++; $display("FAIL plain_wb6_timeout: got timeout want accept"); end
    start_req(5'd5, 5'd6, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || lat !== 3) begin
      failures++; $display("FAIL plain_latency: got %0d (timeout=%0d) want 3", lat, to);
    end
    checks++;
    if (op_rs1_val !== gold[5]) begin
      failures++; $display("FAIL plain_rs1: got %h want %h", op_rs1_val, gold[5]);
    end
    checks++;
    if (op_rs2_val !== gold[6]) begin
      failures++; $display("FAIL plain_rs2: got %h want %h", op_rs2_val, gold[6]);
    end
    finish_op();
  endtask

  task automatic test_x0_guard();
    bit to; int lat;
    do_wb(5'd0, 32'hFFFF_FFFF, to);
    checks++;
    if (to || wb_ready !== 1'b1) begin
      failures++; $display("FAIL x0_wb_drain: got wb_ready=%b timeout=%0d want 1/0", wb_ready, to);
    end
    checks++;
    if (mon_x0 !== 0 || rf_mem[0] !== 32'hBAD0_BAD0) begin
      failures++; $display("FAIL x0_write: got %0d x0 strobes mem0=%h want 0 / bad0bad0", mon_x0, rf_mem[0]);
    end
    start_req(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || lat !== 3) begin
      failures++; $display("FAIL x0_latency: got %0d (timeout=%0d) want 3", lat, to);
    end
    checks++;
    if (op_rs1_val !== 32'd0 || op_rs2_val !== 32'd0) begin
      failures++; $display("FAIL x0_operands: got %h/%h want 0/0", op_rs1_val, op_rs2_val);
    end
    finish_op();
  endtask

  task automatic test_priority();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_A5A5;
    settle();
    checks++;
    if (wb_ready !== 1'b1) begin failures++; $display("FAIL prio_wb_accept: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd5;
    settle();
    checks++;
    if ({req_ready, wb_ready, rf_set_reg} !== 3'b001) begin
      failures++; $display("FAIL prio_write_cycle: got req_ready,wb_ready,set=%b want 001",
                           {req_ready, wb_ready, rf_set_reg});
    end
    checks++;
    if (rf_register_id !== 5'd7 || rf_value !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL prio_write_port: got id=%0d val=%h want 7/a5a5a5a5", rf_register_id, rf_value);
    end
    gold[7] = 32'hA5A5_A5A5;
    tick(); settle();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL prio_req_after_wb: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    tick(); tick(); settle();
    checks++;
    if (op_valid !== 1'b1 || op_rs1_val !== gold[7] || op_rs2_val !== gold[5]) begin
      failures++; $display("FAIL prio_operands: got v=%b %h/%h want 1 %h/%h",
                           op_valid, op_rs1_val, op_rs2_val, gold[7], gold[5]);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    bit to; int lat;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    start_req(5'd5, 5'd7, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || lat !== 3) begin failures++; $display("FAIL bp_latency: got %0d (timeout=%0d) want 3", lat, to); end
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin wb_valid = 1'b1; wb_rd = 5'd11; wb_data = d1; end
      if (k == 2) begin wb_valid = 1'b1; wb_rd = 5'd12; wb_data = d2; end
      settle();
      checks++;
      if ({op_valid, req_ready, rf_set_reg} !== 3'b100 ||
          op_rs1_val !== gold[5] || op_rs2_val !== gold[7]) begin
        failures++; $display("FAIL bp_hold_%0d: got v,rr,set=%b %h/%h want 100 %h/%h", k,
                             {op_valid, req_ready, rf_set_reg}, op_rs1_val, op_rs2_val, gold[5], gold[7]);
      end
      if (k == 0) begin
        checks++;
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL bp_wb1_ready: got %b want 1", wb_ready); end
      end
      if (k >= 2) begin
        checks++;
        if (wb_ready !== 1'b0) begin failures++; $display("FAIL bp_wb2_blocked_%0d: got %b want 0", k, wb_ready); end
      end
      tick();
      if (k == 0) wb_valid = 1'b0;
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    settle();
    checks++;
    if (rf_set_reg !== 1'b1 || rf_register_id !== 5'd11 || rf_value !== d1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL bp_wb1_write: got set=%b id=%0d val=%h rr=%b want 1/11/%h/0",
                           rf_set_reg, rf_register_id, rf_value, req_ready, d1);
    end
    tick(); settle();
    checks++;
    if (wb_ready !== 1'b1) begin failures++; $display("FAIL bp_wb2_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (rf_set_reg !== 1'b1 || rf_register_id !== 5'd12 || rf_value !== d2) begin
      failures++; $display("FAIL bp_wb2_write: got set=%b id=%0d val=%h want 1/12/%h",
                           rf_set_reg, rf_register_id, rf_value, d2);
    end
    gold[11] = d1; gold[12] = d2;
    tick(); settle();
    start_req(5'd11, 5'd12, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || op_rs1_val !== gold[11] || op_rs2_val !== gold[12]) begin
      failures++; $display("FAIL bp_readback: got %h/%h want %h/%h", op_rs1_val, op_rs2_val, gold[11], gold[12]);
    end
    finish_op();
  endtask

  task automatic test_bypass();
    bit to; int lat;
    logic [31:0] exp2;
    do_wb(5'd9, 32'd1, to); gold[9] = 32'd1;
    checks++;
    if (to) begin failures++; $display("FAIL byp_preload: got timeout want accept"); end
`ifdef HY_RF_WB_BYPASS_EN
    exp2 = 32'h55;
`else
    exp2 = gold[9];
`endif
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd9;
    settle();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL byp_req_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    settle();
    checks++;
    if (wb_ready !== 1'b1 || rf_get_reg !== 1'b1 || rf_register_id !== 5'd3) begin
      failures++; $display("FAIL byp_rd1: got wbr=%b get=%b id=%0d want 1/1/3", wb_ready, rf_get_reg, rf_register_id);
    end
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (rf_get_reg !== 1'b1 || rf_set_reg !== 1'b0 || rf_register_id !== 5'd9) begin
      failures++; $display("FAIL byp_rd2: got get=%b set=%b id=%0d want 1/0/9", rf_get_reg, rf_set_reg, rf_register_id);
    end
    tick(); settle();
    checks++;
    if (op_valid !== 1'b1 || op_rs1_val !== gold[3] || op_rs2_val !== exp2) begin
      failures++; $display("FAIL byp_operands: got v=%b %h/%h want 1 %h/%h", op_valid, op_rs1_val, op_rs2_val, gold[3], exp2);
    end
    finish_op();
    checks++;
    if (rf_set_reg !== 1'b1 || rf_register_id !== 5'd9 || rf_value !== 32'h55) begin
      failures++; $display("FAIL byp_late_write: got set=%b id=%0d val=%h want 1/9/55", rf_set_reg, rf_register_id, rf_value);
    end
    gold[9] = 32'h55;
    tick(); settle();
    start_req(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || lat !== 3 || op_rs1_val !== gold[9] || op_rs2_val !== 32'd0) begin
      failures++; $display("FAIL byp_readback: got lat=%0d %h/%h want 3 %h/0", lat, op_rs1_val, op_rs2_val, gold[9]);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    bit to; int lat;
    logic [8:0] outs;
    req_valid = 1'b1; req_rs1 = 5'd4; req_rs2 = 5'd8;
    settle();
    tick();
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 32'hCAFE_F00D;
    settle();
    tick();
    wb_valid = 1'b0;
    settle();
    checks++;
    if (rf_get_reg !== 1'b1 || rf_register_id !== 5'd8) begin
      failures++; $display("FAIL rmid_in_rd2: got get=%b id=%0d want 1/8", rf_get_reg, rf_register_id);
    end
    reset = 1'b1;
    settle();
    outs = {req_ready, wb_ready, op_valid, rf_set_reg, rf_get_reg, |rf_register_id,
            |rf_value, |op_rs1_val, |op_rs2_val};
    checks++;
    if (outs !== 9'd0) begin failures++; $display("FAIL rmid_outputs_in_reset: got %b want 0", outs); end
    tick();
    reset = 1'b0;
    settle();
    outs = {req_ready, wb_ready, op_valid, rf_set_reg, rf_get_reg, |rf_register_id,
            |rf_value, |op_rs1_val, |op_rs2_val};
    checks++;
    if (outs !== 9'b110000000) begin failures++; $display("FAIL rmid_after_reset: got %b want 110000000", outs); end
    tick(); settle();
    checks++;
    if (rf_set_reg !== 1'b0 || wb_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_wb_dropped: got set=%b wbr=%b want 0/1", rf_set_reg, wb_ready);
    end
    start_req(5'd13, 5'd4, 1'b0, 5'd0, 32'd0, lat, to);
    checks++;
    if (to || op_rs1_val !== gold[13] || op_rs2_val !== gold[4]) begin
      failures++; $display("FAIL rmid_readback: got %h/%h want %h/%h", op_rs1_val, op_rs2_val, gold[13], gold[4]);
    end
    finish_op();
  endtask

  task automatic test_random();
    bit to, wb_en; int lat, hold;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] data, e1, e2;
    for (int it = 0; it < 40; it++) begin
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      wb_en = 1'($urandom_range(0, 1));
      do rd = 5'($urandom_range(0, 31)); while (rd == rs1 || rd == rs2);
      data = $urandom;
      hold = $urandom_range(0, 3);
      e1 = gold[rs1];
      e2 = gold[rs2];
      start_req(rs1, rs2, wb_en, rd, data, lat, to);
      checks++;
      if (to || lat !== 3 || op_rs1_val !== e1 || op_rs2_val !== e2) begin
        failures++; $display("FAIL rand_%0d: rs=%0d,%0d got lat=%0d to=%0d %h/%h want 3 %h/%h",
                             it, rs1, rs2, lat, to, op_rs1_val, op_rs2_val, e1, e2);
      end
      for (int h = 0; h < hold; h++) begin
        tick(); settle();
        checks++;
        if (op_valid !== 1'b1 || op_rs1_val !== e1 || op_rs2_val !== e2) begin
          failures++; $display("FAIL rand_hold_%0d_%0d: got v=%b %h/%h want 1 %h/%h",
                               it, h, op_valid, op_rs1_val, op_rs2_val, e1, e2);
        end
      end
      if (wb_en && rd != 5'd0) gold[rd] = data;
      finish_op();
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (mon_excl !== 0) begin failures++; $display("FAIL inv_strobe_exclusive: got %0d overlaps want 0", mon_excl); end
    checks++;
    if (mon_idle_nz !== 0) begin failures++; $display("FAIL inv_idle_port_zero: got %0d cycles want 0", mon_idle_nz); end
    checks++;
    if (mon_x0 !== 0) begin failures++; $display("FAIL inv_no_x0_write: got %0d writes want 0", mon_x0); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gold[i] = (i == 0) ? 32'd0 : init_val(i);
    test_reset();
    test_plain_read();
    test_x0_guard();
    test_priority();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    test_random();
    tick(); tick(); settle();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
